// File: rtl/core_ctrl_if.sv
// Control/handshake bundle between core_ctrl (master) and the datapath and memory ports (slave).
// The performance counter signals exist only when CORE_CTRL_PERF_EN is defined.
`ifndef INST_TYPE_END
`define INST_IMM      0
`define INST_REG      1
`define INST_LOAD     2
`define INST_STORE    3
`define INST_UPP      4
`define INST_AUIPC    5
`define INST_JUMP     6
`define INST_JUMPR    7
`define INST_BRANCH   8
`define INST_SYSTEM   9
`define INST_TYPE_END 9
`endif

interface core_ctrl_if;
    // One-hot decoder class; all-zero marks an illegal instruction.
    logic [`INST_TYPE_END:0] inst_type;
    logic [2:0]              funct3;
    logic                    com_true;

    logic                    imem_req;
    logic                    imem_rvalid;
    logic                    dmem_req;
    logic                    dmem_we;
    logic                    dmem_ack;

    logic                    ir_we;
    logic                    reg_we;
    logic                    csr_we;
    logic                    pc_we;
    logic [1:0]              pc_sel;
    logic                    retire;
    logic                    halted;
    logic [1:0]              trap_cause;
`ifdef CORE_CTRL_PERF_EN
    logic [63:0]             cycle_cnt;
    logic [63:0]             instret_cnt;
`endif

    modport master (
        input  inst_type, funct3, com_true, imem_rvalid, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, reg_we, csr_we,
        output pc_we, pc_sel, retire, halted, trap_cause
`ifdef CORE_CTRL_PERF_EN
        , output cycle_cnt, instret_cnt
`endif
    );

    modport slave (
        output inst_type, funct3, com_true, imem_rvalid, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, reg_we, csr_we,
        input  pc_we, pc_sel, retire, halted, trap_cause
`ifdef CORE_CTRL_PERF_EN
        , input cycle_cnt, instret_cnt
`endif
    );
endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the single-issue RV32I core, trapping on
// illegal, ecall/ebreak or memory timeout. Define CORE_CTRL_PERF_EN to add cycle/instret counters.
module core_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    core_ctrl_if.master bus
);

    localparam int IW = `INST_TYPE_END + 1;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_ECALL   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_REL  = 2'd1;
    localparam logic [1:0] PC_JALR = 2'd2;

    // A request that has already waited TIMEOUT-1 cycles traps if this cycle also goes unanswered.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_TRAP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [1:0]        cause_q;
    logic [1:0]        cause_d;
    logic              store_q;
    logic              cnt_run;

    logic              imem_req_c;
    logic              dmem_req_c;
    logic              dmem_we_c;
    logic              ir_we_c;
    logic              reg_we_c;
    logic              csr_we_c;
    logic              pc_we_c;
    logic [1:0]        pc_sel_c;
    logic              retire_c;
    logic              halted_c;

    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (v == {TO_W{1'b1}}) ? v : v + TO_W'(1);
    endfunction

    function automatic logic writes_rd(input logic [IW-1:0] t);
        return t[`INST_IMM] | t[`INST_REG] | t[`INST_UPP] | t[`INST_AUIPC] |
               t[`INST_JUMP] | t[`INST_JUMPR] | t[`INST_SYSTEM];
    endfunction

    function automatic logic [1:0] next_pc_sel(input logic [IW-1:0] t, input logic taken);
        logic [1:0] sel;
        sel = PC_SEQ;
        if (t[`INST_JUMP])
            sel = PC_REL;
        else if (t[`INST_JUMPR])
            sel = PC_JALR;
        else if (t[`INST_BRANCH] && taken)
            sel = PC_REL;
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_FETCH;
            to_cnt_q <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= cnt_run ? sat_inc(to_cnt_q) : '0;
            if (state_q != ST_TRAP && state_d == ST_TRAP)
                cause_q <= cause_d;
        end
    end

    // Latch the access direction on the way into MEM so dmem_we cannot move mid-request.
    always_ff @(posedge clk) begin
        if (state_q == ST_EXEC)
            store_q <= bus.inst_type[`INST_STORE];
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = CAUSE_NONE;
        cnt_run    = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        csr_we_c   = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = PC_SEQ;
        retire_c   = 1'b0;
        halted_c   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_rvalid) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    cnt_run = 1'b1;
                    if (to_cnt_q >= TO_LAST) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            ST_DECODE: begin
                if (bus.inst_type == '0) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (bus.inst_type[`INST_SYSTEM] && bus.funct3 == 3'd0) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ECALL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.inst_type[`INST_LOAD] || bus.inst_type[`INST_STORE]) begin
                    state_d = ST_MEM;
                end else begin
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    reg_we_c = writes_rd(bus.inst_type);
                    csr_we_c = bus.inst_type[`INST_SYSTEM];
                    pc_sel_c = next_pc_sel(bus.inst_type, bus.com_true);
                    state_d  = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = store_q;
                if (bus.dmem_ack) begin
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    reg_we_c = !store_q;
                    state_d  = ST_FETCH;
                end else begin
                    cnt_run = 1'b1;
                    if (to_cnt_q >= TO_LAST) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            ST_TRAP: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset wins over any handshake in flight, including one completing this edge.
        if (!reset_n) begin
            imem_req_c = 1'b0;
            dmem_req_c = 1'b0;
            dmem_we_c  = 1'b0;
            ir_we_c    = 1'b0;
            reg_we_c   = 1'b0;
            csr_we_c   = 1'b0;
            pc_we_c    = 1'b0;
            pc_sel_c   = PC_SEQ;
            retire_c   = 1'b0;
            halted_c   = 1'b0;
        end
    end

    assign bus.imem_req   = imem_req_c;
    assign bus.dmem_req   = dmem_req_c;
    assign bus.dmem_we    = dmem_we_c;
    assign bus.ir_we      = ir_we_c;
    assign bus.reg_we     = reg_we_c;
    assign bus.csr_we     = csr_we_c;
    assign bus.pc_we      = pc_we_c;
    assign bus.pc_sel     = pc_sel_c;
    assign bus.retire     = retire_c;
    assign bus.halted     = halted_c;
    assign bus.trap_cause = cause_q;

`ifdef CORE_CTRL_PERF_EN
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != ST_TRAP)
                cycle_q <= cycle_q + 64'd1;
            if (retire_c)
                instret_q <= instret_q + 64'd1;
        end
    end

    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: two instances, one with the default TIMEOUT and one with TIMEOUT=4.
`ifndef INST_TYPE_END
`define INST_IMM      0
`define INST_REG      1
`define INST_LOAD     2
`define INST_STORE    3
`define INST_UPP      4
`define INST_AUIPC    5
`define INST_JUMP     6
`define INST_JUMPR    7
`define INST_BRANCH   8
`define INST_SYSTEM   9
`define INST_TYPE_END 9
`endif

module tb_core_ctrl;
    typedef logic [`INST_TYPE_END:0] itype_t;

    localparam itype_t T_ILL    = '0;
    localparam itype_t T_IMM    = itype_t'(1) << `INST_IMM;
    localparam itype_t T_LOAD   = itype_t'(1) << `INST_LOAD;
    localparam itype_t T_STORE  = itype_t'(1) << `INST_STORE;
    localparam itype_t T_JUMP   = itype_t'(1) << `INST_JUMP;
    localparam itype_t T_JUMPR  = itype_t'(1) << `INST_JUMPR;
    localparam itype_t T_BRANCH = itype_t'(1) << `INST_BRANCH;
    localparam itype_t T_SYSTEM = itype_t'(1) << `INST_SYSTEM;

    logic clk = 1'b0;
    logic reset_na;
    logic reset_nb;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    core_ctrl_if ia ();
    core_ctrl_if ib ();

    core_ctrl #(.TIMEOUT(255), .TO_W(8)) u_dut_a (.clk(clk), .reset_n(reset_na), .bus(ia));
    core_ctrl #(.TIMEOUT(4),   .TO_W(8)) u_dut_b (.clk(clk), .reset_n(reset_nb), .bus(ib));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards settle before the next rising edge.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_na = 1'b0;
        reset_nb = 1'b0;
        ia.inst_type = T_IMM; ia.funct3 = 3'd0; ia.com_true = 1'b0;
        ia.imem_rvalid = 1'b0; ia.dmem_ack = 1'b0;
        ib.inst_type = T_STORE; ib.funct3 = 3'd2; ib.com_true = 1'b0;
        ib.imem_rvalid = 1'b1; ib.dmem_ack = 1'b0;
        nxt(); nxt();

        // Reset state while reset_n is still low
        chk("rst_imem_req", ia.imem_req, 1'b0);
        chk("rst_halted", ia.halted, 1'b0);
        chk("rst_cause", ia.trap_cause, 2'd0);
        chk("rst_retire", ia.retire, 1'b0);

        // ADDI stream with imem_rvalid tied high: retire every 3rd cycle
        reset_na = 1'b1; ia.imem_rvalid = 1'b1; #1;
        chk("fetch_req", ia.imem_req, 1'b1);
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("addi_ir_we_%0d", c), ia.ir_we, (c % 3) == 0);
            chk($sformatf("addi_retire_%0d", c), ia.retire, (c % 3) == 2);
            chk($sformatf("addi_reg_we_%0d", c), ia.reg_we, (c % 3) == 2);
            chk($sformatf("addi_pc_we_%0d", c), ia.pc_we, (c % 3) == 2);
            chk($sformatf("addi_pc_sel_%0d", c), ia.pc_sel, 2'd0);
            nxt();
        end

        // Taken branch
        ia.inst_type = T_BRANCH; ia.com_true = 1'b1;
        nxt(); nxt();
        chk("beq_t_pc_sel", ia.pc_sel, 2'd1);
        chk("beq_t_reg_we", ia.reg_we, 1'b0);
        chk("beq_t_retire", ia.retire, 1'b1);
        nxt();
        // Not-taken branch
        ia.com_true = 1'b0;
        nxt(); nxt();
        chk("beq_n_pc_sel", ia.pc_sel, 2'd0);
        chk("beq_n_reg_we", ia.reg_we, 1'b0);
        chk("beq_n_pc_we", ia.pc_we, 1'b1);
        nxt();

        // JAL, JALR, CSR-form SYSTEM
        ia.inst_type = T_JUMP;
        nxt(); nxt();
        chk("jal_pc_sel", ia.pc_sel, 2'd1);
        chk("jal_reg_we", ia.reg_we, 1'b1);
        nxt();
        ia.inst_type = T_JUMPR;
        nxt(); nxt();
        chk("jalr_pc_sel", ia.pc_sel, 2'd2);
        chk("jalr_reg_we", ia.reg_we, 1'b1);
        nxt();
        ia.inst_type = T_SYSTEM; ia.funct3 = 3'd1;
        nxt(); nxt();
        chk("csr_csr_we", ia.csr_we, 1'b1);
        chk("csr_reg_we", ia.reg_we, 1'b1);
        chk("csr_retire", ia.retire, 1'b1);
        nxt();

        // LW with dmem_ack delayed 5 cycles: 9 cycles from FETCH entry
        ia.inst_type = T_LOAD; ia.funct3 = 3'd2;
        chk("lw_c0_ir_we", ia.ir_we, 1'b1);
        nxt();
        chk("lw_c1_decode_pc_we", ia.pc_we, 1'b0);
        nxt();
        chk("lw_c2_exec_retire", ia.retire, 1'b0);
        chk("lw_c2_exec_pc_we", ia.pc_we, 1'b0);
        nxt();
        for (int c = 3; c < 9; c++) begin
            ia.dmem_ack = (c == 8); #1;
            chk($sformatf("lw_dmem_req_%0d", c), ia.dmem_req, 1'b1);
            chk($sformatf("lw_dmem_we_%0d", c), ia.dmem_we, 1'b0);
            chk($sformatf("lw_retire_%0d", c), ia.retire, c == 8);
            chk($sformatf("lw_reg_we_%0d", c), ia.reg_we, c == 8);
            chk($sformatf("lw_pc_we_%0d", c), ia.pc_we, c == 8);
            nxt();
        end
        ia.dmem_ack = 1'b0; #1;
        chk("lw_c9_fetch", ia.imem_req, 1'b1);
        chk("lw_c9_dmem_req", ia.dmem_req, 1'b0);

        // Illegal instruction traps; reset recovers
        ia.inst_type = T_ILL;
        nxt();
        chk("ill_decode_retire", ia.retire, 1'b0);
        nxt();
        chk("ill_halted", ia.halted, 1'b1);
        chk("ill_cause", ia.trap_cause, 2'd1);
        chk("ill_retire", ia.retire, 1'b0);
        chk("ill_imem_req", ia.imem_req, 1'b0);
        nxt();
        chk("ill_hold_cause", ia.trap_cause, 2'd1);
        reset_na = 1'b0; #1;
        chk("ill_rst_halted", ia.halted, 1'b0);
        nxt();
        reset_na = 1'b1; #1;
        chk("ill_rel_halted", ia.halted, 1'b0);
        chk("ill_rel_cause", ia.trap_cause, 2'd0);
        chk("ill_rel_fetch", ia.imem_req, 1'b1);

        // ecall traps with cause 2
        ia.inst_type = T_SYSTEM; ia.funct3 = 3'd0;
        nxt(); nxt();
        chk("ecall_halted", ia.halted, 1'b1);
        chk("ecall_cause", ia.trap_cause, 2'd2);
        reset_na = 1'b0;
        nxt();
        reset_na = 1'b1; #1;
        chk("ecall_rel_cause", ia.trap_cause, 2'd0);

        // Reset asserted mid-MEM with dmem_ack arriving the same edge
        ia.inst_type = T_LOAD; ia.funct3 = 3'd2;
        nxt(); nxt(); nxt();
        chk("mrst_in_mem", ia.dmem_req, 1'b1);
        reset_na = 1'b0; ia.dmem_ack = 1'b1; #1;
        chk("mrst_retire", ia.retire, 1'b0);
        chk("mrst_reg_we", ia.reg_we, 1'b0);
        nxt();
        reset_na = 1'b1; ia.dmem_ack = 1'b0; #1;
        chk("mrst_fetch", ia.imem_req, 1'b1);
        chk("mrst_dmem_req", ia.dmem_req, 1'b0);
        nxt();
        chk("mrst_decode", ia.imem_req, 1'b0);

        // TIMEOUT=4 instance: SW retires, then fetch times out after 4 cycles
        reset_nb = 1'b1; #1;
        chk("sw_ir_we", ib.ir_we, 1'b1);
        nxt(); nxt(); nxt();
        ib.dmem_ack = 1'b1; #1;
        chk("sw_dmem_req", ib.dmem_req, 1'b1);
        chk("sw_dmem_we", ib.dmem_we, 1'b1);
        chk("sw_retire", ib.retire, 1'b1);
        chk("sw_reg_we", ib.reg_we, 1'b0);
        chk("sw_pc_we", ib.pc_we, 1'b1);
        nxt();
        ib.dmem_ack = 1'b0; ib.imem_rvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("to_fetch_req_%0d", c), ib.imem_req, 1'b1);
            chk($sformatf("to_halted_%0d", c), ib.halted, 1'b0);
            nxt();
        end
        chk("to_halted", ib.halted, 1'b1);
        chk("to_cause", ib.trap_cause, 2'd3);
        chk("to_imem_req", ib.imem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Multi-cycle sequencer for the single-issue RV32I soc core.
- Drives instruction fetch, instruction register load, execute commit and load/store handshakes.
- Consumes `inst_type` from the decoder and the branch compare result; produces the write enables and selects for the PC, IR, register file, CSRs and the memory ports.
- Traps and halts on an illegal instruction, an ecall/ebreak, or a memory timeout.

Parameters:
- TIMEOUT, 255: max cycles a memory request may wait for its response before trapping; must be ≥1.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- inst_type  in  INST_TYPE_END+1  decoder class; encodings from inst_defines (INST_IMM, INST_REG, INST_LOAD, INST_STORE, INST_UPP, INST_AUIPC, INST_JUMP, INST_JUMPR, INST_BRANCH, INST_SYSTEM); 0 = illegal.
- com_true  in  1  branch compare result for the current instruction.
- imem_req  out  1  instruction fetch request.
- imem_rvalid  in  1  fetch data valid; handshake completes when imem_req && imem_rvalid.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ack  in  1  data access complete; handshake completes when dmem_req && dmem_ack.
- ir_we  out  1  latch fetched word into IR.
- reg_we  out  1  register-file write strobe.
- csr_we  out  1  CSR write strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  0 = pc+4, 1 = pc+imm (JAL / taken branch), 2 = (rs1+imm)&~1 (JALR), 3 = reserved.
- retire  out  1  one-cycle pulse per committed instruction.
- halted  out  1  core stopped in TRAP.
- trap_cause  out  2  0 = none, 1 = illegal, 2 = ecall/ebreak, 3 = memory timeout.

Behaviour:
- Reset: while reset_n=0 at a clk edge, state←FETCH, timeout counter←0, trap_cause←0.
  - All strobes/requests and halted are 0 during reset.
  - Reset overrides everything, including an in-flight handshake; a response arriving during reset is ignored.
- States: FETCH, DECODE, EXEC, MEM, TRAP.
- FETCH:
  - imem_req=1 continuously.
  - On handshake: ir_we=1 that same cycle; next state DECODE.
  - Otherwise the counter increments; when it reaches TIMEOUT → TRAP, cause 3.
- DECODE: no strobes; inst_type is valid from IR.
  - inst_type==0 → TRAP, cause 1.
  - SYSTEM with funct3 field 0 (ecall/ebreak) → TRAP, cause 2.
  - All other classes → EXEC.
- EXEC:
  - LOAD/STORE classes: no commit; counter←0; → MEM.
  - All other classes commit this cycle: pc_we=1, retire=1, then → FETCH.
  - reg_we=1 for IMM, REG, UPP, AUIPC, JUMP, JUMPR.
  - csr_we=1 and reg_we=1 for CSR-form SYSTEM.
  - pc_sel by class:
    - JUMP: 1.
    - JUMPR: 2.
    - BRANCH: 1 if com_true, else 0.
    - All others: 0.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE, 0 for LOAD; held stable until the handshake.
  - On handshake: pc_we=1, pc_sel=0, retire=1, reg_we=1 for LOAD only; → FETCH.
  - Timeout as in FETCH → TRAP, cause 3.
- TRAP:
  - halted=1; all strobes and requests 0.
  - trap_cause holds its value; only reset exits.
- Latency:
  - Non-memory instruction: 3 cycles when imem_rvalid arrives in the first FETCH cycle.
  - Load/store: 4 cycles with zero-wait memory.
- Timeout counter: cleared on entering FETCH or MEM; saturating, never wraps.
- Every output is a pure function of the current state plus the current-cycle handshake inputs; there are no registered strobes.

Optional Feature:
- Macro: CORE_CTRL_PERF_EN.
- When defined, adds outputs `cycle_cnt` and `instret_cnt`, 64 bits each.
  - cycle_cnt increments every cycle that is not TRAP and not reset.
  - instret_cnt increments on each retire.
  - Both cleared by reset and wrap modulo 2^64.
- When undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- ADDI stream, imem_rvalid tied 1:
  - retire every 3rd cycle.
  - reg_we and pc_we coincide with retire; pc_sel=0.
- BEQ with com_true=1, then com_true=0:
  - pc_sel=1, then pc_sel=0, in the EXEC cycle.
  - reg_we=0 in both.
- LW with dmem_ack delayed 5 cycles:
  - dmem_req=1 and dmem_we=0 for 6 cycles.
  - reg_we, pc_we and retire pulse in the ack cycle.
  - Total 9 cycles from FETCH entry.
- SW, then imem_rvalid held 0 with TIMEOUT=4:
  - Store retires with reg_we=0.
  - Next FETCH traps after 4 cycles: halted=1, trap_cause=3.
- inst_type=0 in DECODE:
  - Next cycle halted=1, trap_cause=1; no retire.
  - reset_n=0 for one edge → FETCH, halted=0, trap_cause=0.
- reset_n asserted mid-MEM with dmem_ack arriving the same edge:
  - no retire, no reg_we.
  - State is FETCH after reset release.
